// File: rtl/cmp_arbiter.sv
// Shared comparator datapath arbitrated among NUM_REQ requesters.
// Operands are latched on grant, compared in CMP, and the result is held in RESP until consumed.
module cmp_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 32,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    rsp_result,
    output logic [4:0]              rsp_flags,
    output logic                    busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q;
    logic [2:0]      op_q;
    logic [IdW-1:0]  id_q, last_q;
    logic            result_q;
    logic [4:0]      flags_q;

    logic            found;
    logic [IdW-1:0]  win, cand;
    int unsigned     idx;

    // Winner scan: rotate the start point past the last grant when round-robin is enabled.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (RR_EN) idx = (32'(last_q) + 1 + i) % NUM_REQ;
            else       idx = i;
            cand = IdW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic eq, lt_s, gt_s, lt_u, gt_u, res_d;

    always_comb begin
        eq   = (a_q == b_q);
        lt_s = ($signed(a_q) < $signed(b_q));
        gt_s = ($signed(a_q) > $signed(b_q));
        lt_u = (a_q < b_q);
        gt_u = (a_q > b_q);
        res_d = 1'b0;
        unique case (op_q)
            3'b000: res_d = eq;
            3'b001: res_d = !eq;
            3'b010: res_d = lt_s;
            3'b011: res_d = lt_u;
            3'b100: res_d = lt_s;
            3'b101: res_d = !lt_s;
            3'b110: res_d = lt_u;
            3'b111: res_d = !lt_u;
            default: res_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    state_d        = StCmp;
                end
            end
            StCmp: state_d = StResp;
            StResp: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= '0;
            last_q   <= IdW'(NUM_REQ - 1);
            result_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && found) begin
                a_q    <= req_a[32'(win) * XLEN +: XLEN];
                b_q    <= req_b[32'(win) * XLEN +: XLEN];
                op_q   <= req_op[32'(win) * 3 +: 3];
                id_q   <= win;
                last_q <= win;
            end
            if (state_q == StCmp) begin
                result_q <= res_d;
                flags_q  <= {eq, lt_s, gt_s, lt_u, gt_u};
            end
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and table-driven bench for cmp_arbiter; a fixed-priority twin shares the stimulus.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  req_ready, rsp_valid, req_ready_fp, rsp_valid_fp;
    logic        rsp_result, rsp_result_fp, busy, busy_fp;
    logic [4:0]  rsp_flags, rsp_flags_fp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.NUM_REQ(2), .XLEN(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    cmp_arbiter #(.NUM_REQ(2), .XLEN(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_fp),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid_fp),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result_fp), .rsp_flags(rsp_flags_fp),
        .busy(busy_fp)
    );

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        res;
        logic [4:0]  flags;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op);
        req_valid[r]       = 1'b1;
        req_a[r*32 +: 32]  = a;
        req_b[r*32 +: 32]  = b;
        req_op[r*3 +: 3]   = op;
    endtask

    // Flags {eq, lt_s, gt_s, lt_u, gt_u} and the op decode, written from the definitions.
    function automatic logic [5:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        logic eq, lts, gts, ltu, gtu, res;
        eq  = (a == b);
        lts = ($signed(a) < $signed(b));
        gts = ($signed(a) > $signed(b));
        ltu = (a < b);
        gtu = (a > b);
        case (op)
            3'd0: res = eq;
            3'd1: res = !eq;
            3'd2, 3'd4: res = lts;
            3'd3, 3'd6: res = ltu;
            3'd5: res = !lts;
            default: res = !ltu;
        endcase
        return {res, eq, lts, gts, ltu, gtu};
    endfunction

    // Starts and ends #1 after a rising edge.
    task automatic txn(input string nm, input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic er, input logic [4:0] ef);
        drive_req(r, a, b, op);
        @(negedge clk);
        chk({nm, " req_ready"}, 32'(req_ready), 32'(1 << r));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({nm, " cmp busy"}, 32'(busy), 32'd1);
        chk({nm, " cmp rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
        chk({nm, " result"}, 32'(rsp_result), 32'(er));
        chk({nm, " flags"}, 32'(rsp_flags), 32'(ef));
        rsp_ready = 2'(1 << r);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk({nm, " idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 32'd5,        32'd5,        3'b000, 1'b1, 5'b10000};
        vecs[1] = '{1, 32'hFFFFFFFF, 32'd1,        3'b100, 1'b1, 5'b01001};
        vecs[2] = '{0, 32'hFFFFFFFF, 32'd1,        3'b110, 1'b0, 5'b01001};
        vecs[3] = '{1, 32'd5,        32'd5,        3'b001, 1'b0, 5'b10000};
        vecs[4] = '{0, 32'd3,        32'd7,        3'b010, 1'b1, 5'b01010};
        vecs[5] = '{1, 32'd7,        32'd3,        3'b011, 1'b0, 5'b00101};
        vecs[6] = '{0, 32'h80000000, 32'h7FFFFFFF, 3'b101, 1'b0, 5'b01001};
        vecs[7] = '{1, 32'd1,        32'hFFFFFFFF, 3'b111, 1'b0, 5'b00110};
        vecs[8] = '{0, 32'd9,        32'd2,        3'b111, 1'b1, 5'b00101};
        vecs[9] = '{1, 32'd0,        32'd0,        3'b101, 1'b1, 5'b10000};

        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset result", 32'(rsp_result), 32'd0);
        chk("reset flags", 32'(rsp_flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle no grant", 32'(req_ready), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].flags);

        // Backpressure: req1 held in RESP, req0 waiting, wrong-index rsp_ready ignored.
        drive_req(1, 32'h10, 32'h20, 3'b010);
        @(negedge clk);
        chk("bp grant1", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drive_req(0, 32'h40, 32'h40, 3'b000);
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp cmp no grant", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", 32'(rsp_valid), 32'd2);
            chk("bp result", 32'(rsp_result), 32'd1);
            chk("bp flags", 32'(rsp_flags), 32'(5'b01010));
            chk("bp no grant", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("bp grant0 after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp rsp0 valid", 32'(rsp_valid), 32'd1);
        chk("bp rsp0 result", 32'(rsp_result), 32'd1);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;

        // Reset while in CMP, then while in RESP.
        drive_req(0, 32'd1, 32'd2, 3'b010);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst cmp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst cmp busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_req(1, 32'd3, 32'd3, 3'b000);
        @(negedge clk);
        chk("rst req1 grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pre resp", 32'(rsp_valid), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst resp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst resp busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst both rr", 32'(req_ready), 32'd1);
        chk("rst both fp", 32'(req_ready_fp), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 2'b00;

        // Contention after a fresh reset: RR rotates, fixed priority stays at 0.
        reset_pulse();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 2'b00 && n < 10);
            chk($sformatf("rr grant%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("fp grant%0d", k), 32'(req_ready_fp), 32'd1);
            if (n > 1) chk($sformatf("spacing%0d", k), 32'(n), 32'd3);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 2'b00;

        // Random operands against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            logic [5:0]  m;
            int          r;
            r  = int'($urandom_range(0, 1));
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            if (i % 7 == 0) b = ~a;
            op = 3'($urandom_range(0, 7));
            m  = model(a, b, op);
            txn($sformatf("rnd%0d", i), r, a, b, op, m[5], m[4:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
